// File: rtl/pic_seq_pkg.sv
// ----------------------------------------------------------------------------
// pic_seq_pkg
// Shared types and constants for the PIC16F84 Q-cycle execute sequencer:
// datapath widths, the Q-phase state enum and the instruction field codes.
// No ports.
// ----------------------------------------------------------------------------
package pic_seq_pkg;

   localparam int INSTR_W = 14;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      Q1   = 3'd1,
      Q2   = 3'd2,
      Q3   = 3'd3,
      Q4   = 3'd4
   } q_state_t;

   // ir[13:12] instruction class
   localparam logic [1:0] BYTEOP = 2'b00;
   localparam logic [1:0] BITOP  = 2'b01;

   // ir[11:10] bit-oriented sub-op
   localparam logic [1:0] KK_BCF   = 2'b00;
   localparam logic [1:0] KK_BSF   = 2'b01;
   localparam logic [1:0] KK_BTFSC = 2'b10;
   localparam logic [1:0] KK_BTFSS = 2'b11;

   // ir[11:8] byte-oriented opcodes
   localparam logic [3:0] OP_MOVWF = 4'b0000;
   localparam logic [3:0] OP_CLR   = 4'b0001;
   localparam logic [3:0] OP_SUBWF = 4'b0010;
   localparam logic [3:0] OP_DECF  = 4'b0011;
   localparam logic [3:0] OP_IORWF = 4'b0100;
   localparam logic [3:0] OP_ANDWF = 4'b0101;
   localparam logic [3:0] OP_XORWF = 4'b0110;
   localparam logic [3:0] OP_ADDWF = 4'b0111;
   localparam logic [3:0] OP_MOVF  = 4'b1000;
   localparam logic [3:0] OP_COMF  = 4'b1001;
   localparam logic [3:0] OP_INCF  = 4'b1010;
   localparam logic [3:0] OP_RRF   = 4'b1100;
   localparam logic [3:0] OP_RLF   = 4'b1101;

   localparam logic [6:0] ALU_NOP = 7'b0000000;

endpackage

// File: rtl/pic_exec_sequencer_if.sv
// ----------------------------------------------------------------------------
// pic_exec_sequencer_if
// Bundles the fetch handshake, file-register RAM port, ALU hookup and STATUS
// flags of the execute sequencer.
//   slave  : sequencer side (drives instr_ready, f_*, alu_op/alu_f_in, status)
//   master : environment side (fetch stage, RAM, ALU)
// Optional: ZERO_FLAG_EN adds status_z.
// ----------------------------------------------------------------------------
interface pic_exec_sequencer_if;
   import pic_seq_pkg::*;

   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ready;
   logic [ADDR_W-1:0]  f_addr;
   logic               f_rd;
   logic [DATA_W-1:0]  f_rdata;
   logic               f_wr;
   logic [DATA_W-1:0]  f_wdata;
   logic [6:0]         alu_op;
   logic [DATA_W-1:0]  alu_f_in;
   logic [DATA_W-1:0]  alu_f_out;
   logic [DATA_W-1:0]  alu_w;
   logic               alu_c;
   logic               status_c;
`ifdef ZERO_FLAG_EN
   logic               status_z;
`endif
   logic               unsupported;

   modport slave (
`ifdef ZERO_FLAG_EN
      output status_z,
`endif
      input  instr, instr_valid, f_rdata, alu_f_out, alu_w, alu_c,
      output instr_ready, f_addr, f_rd, f_wr, f_wdata, alu_op, alu_f_in,
             status_c, unsupported
   );

   modport master (
`ifdef ZERO_FLAG_EN
      input  status_z,
`endif
      output instr, instr_valid, f_rdata, alu_f_out, alu_w, alu_c,
      input  instr_ready, f_addr, f_rd, f_wr, f_wdata, alu_op, alu_f_in,
             status_c, unsupported
   );

endinterface

// File: rtl/pic_exec_sequencer_decode.sv
// ----------------------------------------------------------------------------
// pic_instr_decode
// Combinational decode of the opcode field of a PIC16F84 instruction.
//   i_ir           in  7  opcode field, instruction bits [13:7]
//   o_writes_f     out 1  result is written back to the file register
//   o_affects_c    out 1  instruction updates STATUS C
//   o_affects_z    out 1  instruction updates STATUS Z
//   o_is_btfsc     out 1  BTFSC
//   o_is_btfss     out 1  BTFSS
//   o_bit_idx      out 3  bit number for bit-oriented ops
//   o_unsupported  out 1  literal/control class, executed as NOP
// ----------------------------------------------------------------------------
module pic_instr_decode
   import pic_seq_pkg::*;
(
   input  logic [6:0] i_ir,
   output logic       o_writes_f,
   output logic       o_affects_c,
   output logic       o_affects_z,
   output logic       o_is_btfsc,
   output logic       o_is_btfss,
   output logic [2:0] o_bit_idx,
   output logic       o_unsupported
);

   logic [1:0] w_cls;
   logic [3:0] w_op;
   logic [1:0] w_kk;
   logic       w_d;

   assign w_cls = i_ir[6:5];
   assign w_op  = i_ir[4:1];
   assign w_kk  = i_ir[4:3];
   assign w_d   = i_ir[0];

   always_comb begin
      o_writes_f    = 1'b0;
      o_affects_c   = 1'b0;
      o_affects_z   = 1'b0;
      o_is_btfsc    = 1'b0;
      o_is_btfss    = 1'b0;
      o_bit_idx     = i_ir[2:0];
      o_unsupported = 1'b0;
      case (w_cls)
         BYTEOP: begin
            // d=1 covers MOVWF and CLRF; d=0 in the 0000 row is NOP/control
            o_writes_f = w_d;
            case (w_op)
               OP_ADDWF, OP_SUBWF: begin
                  o_affects_c = 1'b1;
                  o_affects_z = 1'b1;
               end
               OP_RRF, OP_RLF:
                  o_affects_c = 1'b1;
               OP_CLR, OP_DECF, OP_IORWF, OP_ANDWF, OP_XORWF,
               OP_MOVF, OP_COMF, OP_INCF:
                  o_affects_z = 1'b1;
               default: ;
            endcase
         end
         BITOP: begin
            case (w_kk)
               KK_BCF, KK_BSF: o_writes_f = 1'b1;
               KK_BTFSC:       o_is_btfsc = 1'b1;
               KK_BTFSS:       o_is_btfss = 1'b1;
               default: ;
            endcase
         end
         default: o_unsupported = 1'b1;
      endcase
   end

endmodule

// File: rtl/pic_exec_sequencer.sv
// ----------------------------------------------------------------------------
// pic_exec_sequencer
// Q-cycle execute sequencer for the PIC16F84 byte/bit ALU. Takes one
// instruction every four clocks, reads the file register in Q2, drives the
// ALU opcode in Q3, writes back in Q4 and maintains STATUS C (and Z).
// BTFSC/BTFSS skips turn the following instruction into a NOP.
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of pic_exec_sequencer_if (handshake, RAM, ALU, flags)
// Optional: ZERO_FLAG_EN enables the STATUS Z flag (bus.status_z).
//
//   state | meaning
//   IDLE  | waiting for an instruction, instr_ready=1
//   Q1    | decode, unsupported pulse
//   Q2    | file-register read strobe
//   Q3    | ALU opcode driven, operand captured, skip condition sampled
//   Q4    | write-back, flag update, instr_ready=1
// ----------------------------------------------------------------------------
module pic_exec_sequencer
   import pic_seq_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   pic_exec_sequencer_if.slave     bus
);

   q_state_t           r_state;
   q_state_t           w_state_nxt;
   logic [INSTR_W-1:0] r_ir;
   logic [DATA_W-1:0]  r_f_in;
   logic               r_skip_pend;
   logic               r_skip_act;
   logic               r_status_c;
`ifdef ZERO_FLAG_EN
   logic               r_status_z;
   logic [DATA_W-1:0]  w_result;
`endif

   logic               w_writes_f;
   logic               w_affects_c;
   logic               w_affects_z;
   logic               w_is_btfsc;
   logic               w_is_btfss;
   logic [2:0]         w_bit_idx;
   logic               w_unsupported;

   logic               w_ready;
   logic               w_accept;
   logic               w_nop;
   logic               w_test_bit;
   logic               w_f_rd;
   logic               w_f_wr;
   logic [DATA_W-1:0]  w_f_wdata;
   logic [6:0]         w_alu_op;
   logic [DATA_W-1:0]  w_alu_f_in;
   logic               w_uns_pulse;

   pic_instr_decode u_decode (
      .i_ir          (r_ir[13:7]),
      .o_writes_f    (w_writes_f),
      .o_affects_c   (w_affects_c),
      .o_affects_z   (w_affects_z),
      .o_is_btfsc    (w_is_btfsc),
      .o_is_btfss    (w_is_btfss),
      .o_bit_idx     (w_bit_idx),
      .o_unsupported (w_unsupported)
   );

   assign w_accept   = bus.instr_valid & w_ready;
   // skipped and unsupported instructions both walk the Q phases inertly
   assign w_nop      = r_skip_act | w_unsupported;
   assign w_test_bit = bus.f_rdata[w_bit_idx];

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_f_rd      = 1'b0;
      w_f_wr      = 1'b0;
      w_f_wdata   = '0;
      w_alu_op    = ALU_NOP;
      w_alu_f_in  = r_f_in;
      w_uns_pulse = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (bus.instr_valid) w_state_nxt = Q1;
         end
         Q1: begin
            w_uns_pulse = w_unsupported;
            w_state_nxt = Q2;
         end
         Q2: begin
            w_f_rd      = ~w_nop;
            w_state_nxt = Q3;
         end
         Q3: begin
            if (!w_nop) begin
               w_alu_op   = r_ir[13:7];
               // RAM data arrives this phase; pass it straight to the ALU so
               // the Q3->Q4 edge computes on it, and hold it afterwards
               w_alu_f_in = bus.f_rdata;
            end
            w_state_nxt = Q4;
         end
         Q4: begin
            w_ready     = 1'b1;
            w_f_wdata   = bus.alu_f_out;
            w_f_wr      = w_writes_f & ~w_nop;
            w_state_nxt = bus.instr_valid ? Q1 : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef ZERO_FLAG_EN
   assign w_result = r_ir[7] ? bus.alu_f_out : bus.alu_w;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ir        <= '0;
         r_f_in      <= '0;
         r_skip_pend <= 1'b0;
         r_skip_act  <= 1'b0;
         r_status_c  <= 1'b0;
`ifdef ZERO_FLAG_EN
         r_status_z  <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_ir <= bus.instr;
            // pend and act both high only in the skipped instruction's Q4,
            // where the pending skip is consumed and must not carry over
            r_skip_act <= r_skip_pend & ~r_skip_act;
         end
         if (r_state == Q3 && !w_nop) begin
            r_f_in <= bus.f_rdata;
            if ((w_is_btfsc && !w_test_bit) || (w_is_btfss && w_test_bit))
               r_skip_pend <= 1'b1;
         end
         if (r_state == Q4) begin
            if (r_skip_act) r_skip_pend <= 1'b0;
            if (!w_nop && w_affects_c) r_status_c <= bus.alu_c;
`ifdef ZERO_FLAG_EN
            if (!w_nop && w_affects_z) r_status_z <= (w_result == '0);
`endif
         end
      end
   end

   assign bus.instr_ready = w_ready;
   assign bus.f_addr      = r_ir[6:0];
   assign bus.f_rd        = w_f_rd;
   assign bus.f_wr        = w_f_wr;
   assign bus.f_wdata     = w_f_wdata;
   assign bus.alu_op      = w_alu_op;
   assign bus.alu_f_in    = w_alu_f_in;
   assign bus.status_c    = r_status_c;
`ifdef ZERO_FLAG_EN
   assign bus.status_z    = r_status_z;
`endif
   assign bus.unsupported = w_uns_pulse;

endmodule
